// File: rtl/bit_serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock, LSB first.
// A single gate-level full adder is time-shared across all bit positions.
// The loop is closed by a carry flop, and a three-state controller runs the sequence.

// Gate-level one-bit full adder cell.
module full_adder (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic cin
);
    logic axb;
    logic ab;
    logic cx;

    xor g_axb (axb, a, b);
    xor g_sum (sum, axb, cin);
    and g_ab  (ab, a, b);
    and g_cx  (cx, axb, cin);
    or  g_cy  (carry, ab, cx);
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operand captured on the accepting edge.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
    } req_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_sr, a_sr_n;
    logic [WIDTH-1:0] b_sr, b_sr_n;
    // Holds the result bits produced so far, MSB-aligned. The bit produced
    // on the final edge comes directly from the cell, so WIDTH-1 bits suffice.
    logic [WIDTH-2:0] s_sr, s_sr_n;
    logic             carry, carry_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             busy_n;
    logic             done_n;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n;

    logic             fa_sum;
    logic             fa_carry;
    req_t             req;

    assign req = '{a: a, b: b, cin: cin};

    full_adder u_fa (
        .sum   (fa_sum),
        .carry (fa_carry),
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (carry)
    );

    // Next-state and datapath decode; every register holds unless a state says otherwise.
    always_comb begin
        state_n = state;
        a_sr_n  = a_sr;
        b_sr_n  = b_sr;
        s_sr_n  = s_sr;
        carry_n = carry;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        sum_n   = sum;
        cout_n  = cout;

        case (state)
            IDLE: begin
                if (start) begin
                    a_sr_n  = req.a;
                    b_sr_n  = req.b;
                    carry_n = req.cin;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end

            SHIFT: begin
                carry_n = fa_carry;
                s_sr_n  = (WIDTH-1)'({fa_sum, s_sr} >> 1);
                a_sr_n  = a_sr >> 1;
                b_sr_n  = b_sr >> 1;
                cnt_n   = cnt + 1'b1;
                if (cnt == LAST) begin
                    // The completion edge is the only point where sum/cout move.
                    sum_n   = {fa_sum, s_sr};
                    cout_n  = fa_carry;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = DONE;
                end
            end

            DONE: begin
                if (start) begin
                    a_sr_n  = req.a;
                    b_sr_n  = req.b;
                    carry_n = req.cin;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_n;
            a_sr  <= a_sr_n;
            b_sr  <= b_sr_n;
            s_sr  <= s_sr_n;
            carry <= carry_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            sum   <= sum_n;
            cout  <= cout_n;
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=13 instances).
// Each accepted start pushes the expected result and completion cycle; each
// done pulse pops and compares.
module tb_bit_serial_adder;
    localparam int W8  = 8;
    localparam int W13 = 13;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start8 = 1'b0, cin8 = 1'b0;
    logic [W8-1:0]  a8 = '0, b8 = '0;
    logic           busy8, done8, cout8;
    logic [W8-1:0]  sum8;
    logic           start13 = 1'b0, cin13 = 1'b0;
    logic [W13-1:0] a13 = '0, b13 = '0;
    logic           busy13, done13, cout13;
    logic [W13-1:0] sum13;

    int     checks = 0;
    int     errs   = 0;
    longint cyc    = 0;

    typedef struct {
        int unsigned val;
        longint      due;
    } ent_t;
    ent_t q8[$];
    ent_t q13[$];

    bit_serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(W13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
        .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the 8-bit instance: pop on done, push on an accepted start.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            q8.delete();
        end else begin
            if (done8) begin
                checks++;
                if (q8.size() == 0) begin
                    errs++;
                    $display("FAIL sb8_unexpected_done: got sum=%h cout=%b with nothing pending", sum8, cout8);
                end else begin
                    e = q8.pop_front();
                    if (32'({cout8, sum8}) !== e.val || cyc != e.due)
                        begin
                            errs++;
                            $display("FAIL sb8_result: got %h at cycle %0d, want %h at cycle %0d",
                                     {cout8, sum8}, cyc, e.val, e.due);
                        end
                end
            end
            if (start8 && !busy8) begin
                e.val = 32'(a8) + 32'(b8) + 32'(cin8);
                e.due = cyc + 1 + W8;
                q8.push_back(e);
            end
        end
    end

    // Scoreboard for the 13-bit instance.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            q13.delete();
        end else begin
            if (done13) begin
                checks++;
                if (q13.size() == 0) begin
                    errs++;
                    $display("FAIL sb13_unexpected_done: got sum=%h cout=%b with nothing pending", sum13, cout13);
                end else begin
                    e = q13.pop_front();
                    if (32'({cout13, sum13}) !== e.val || cyc != e.due)
                        begin
                            errs++;
                            $display("FAIL sb13_result: got %h at cycle %0d, want %h at cycle %0d",
                                     {cout13, sum13}, cyc, e.val, e.due);
                        end
                end
            end
            if (start13 && !busy13) begin
                e.val = 32'(a13) + 32'(b13) + 32'(cin13);
                e.due = cyc + 1 + W13;
                q13.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 50) begin tick(); n++; end
        if (busy8) begin
            checks++; errs++;
            $display("FAIL idle8_timeout: busy=%b, want 0 within 50 cycles", busy8);
        end
    endtask

    task automatic wait_idle13();
        int n = 0;
        while (busy13 && n < 50) begin tick(); n++; end
        if (busy13) begin
            checks++; errs++;
            $display("FAIL idle13_timeout: busy=%b, want 0 within 50 cycles", busy13);
        end
    endtask

    // Start one 8-bit op, scramble inputs after acceptance, return on its done pulse.
    task automatic run8(input logic [W8-1:0] av, input logic [W8-1:0] bv, input logic cv);
        int n = 0;
        wait_idle8();
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = W8'($urandom); b8 = W8'($urandom); cin8 = 1'($urandom);
        while (!done8 && n < W8 + 5) begin tick(); n++; end
        if (!done8) begin
            checks++; errs++;
            $display("FAIL done8_timeout: done=%b, want 1 within %0d cycles", done8, W8 + 5);
        end
    endtask

    task automatic run13(input logic [W13-1:0] av, input logic [W13-1:0] bv, input logic cv);
        int n = 0;
        wait_idle13();
        a13 = av; b13 = bv; cin13 = cv; start13 = 1'b1;
        tick();
        start13 = 1'b0;
        a13 = W13'($urandom); b13 = W13'($urandom); cin13 = 1'($urandom);
        while (!done13 && n < W13 + 5) begin tick(); n++; end
        if (!done13) begin
            checks++; errs++;
            $display("FAIL done13_timeout: done=%b, want 1 within %0d cycles", done13, W13 + 5);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start8 = ~start8; start13 = ~start13;
            tick();
            checks++;
            if ({busy8, done8, sum8, cout8} !== '0 || {busy13, done13, sum13, cout13} !== '0) begin
                errs++;
                $display("FAIL reset_hold: busy/done/sum/cout = %b%b%h%b / %b%b%h%b, want all 0",
                         busy8, done8, sum8, cout8, busy13, done13, sum13, cout13);
            end
        end
        start8 = 1'b0; start13 = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({busy8, done8, sum8, cout8} !== '0 || {busy13, done13, sum13, cout13} !== '0) begin
                errs++;
                $display("FAIL reset_idle: outputs moved after release, 8b=%b%b%h%b, want 0",
                         busy8, done8, sum8, cout8);
            end
        end
    endtask

    task automatic test_latency();
        wait_idle8();
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < W8; i++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errs++;
                $display("FAIL lat_busy[%0d]: busy=%b done=%b, want busy=1 done=0", i, busy8, done8);
            end
            if (i < W8 - 1) tick();
        end
        tick();
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
            errs++;
            $display("FAIL lat_done: busy=%b done=%b sum=%h cout=%b, want 0 1 00 1", busy8, done8, sum8, cout8);
        end
        tick();
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errs++;
            $display("FAIL lat_pulse: done=%b busy=%b one cycle later, want 0 0", done8, busy8);
        end
    endtask

    task automatic test_two_ops();
        int n = 0;
        run8(8'hA5, 8'h5A, 1'b1);
        checks++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
            errs++;
            $display("FAIL two_first: sum=%h cout=%b, want 00 1", sum8, cout8);
        end
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        while (!done8 && n < W8 + 5) begin
            checks++;
            if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
                errs++;
                $display("FAIL two_hold: sum=%h cout=%b mid-op, want 00 1", sum8, cout8);
            end
            tick(); n++;
        end
        checks++;
        if (done8 !== 1'b1 || sum8 !== 8'h46 || cout8 !== 1'b0) begin
            errs++;
            $display("FAIL two_second: done=%b sum=%h cout=%b, want 1 46 0", done8, sum8, cout8);
        end
    endtask

    task automatic test_ignored_start();
        int extra = 0;
        int n = 0;
        wait_idle8();
        tick();
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        while (!done8 && n < W8 + 5) begin tick(); n++; end
        checks++;
        if (done8 !== 1'b1 || sum8 !== 8'h10 || cout8 !== 1'b0) begin
            errs++;
            $display("FAIL ign_result: done=%b sum=%h cout=%b, want 1 10 0", done8, sum8, cout8);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) extra++;
        end
        checks++;
        if (extra != 0) begin
            errs++;
            $display("FAIL ign_single: %0d extra busy/done cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        longint last = -1;
        int ndone = 0;
        wait_idle8();
        tick();
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done8) begin
                checks++;
                if (busy8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
                    errs++;
                    $display("FAIL b2b_done: busy=%b sum=%h cout=%b, want 0 00 1", busy8, sum8, cout8);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != W8 + 1) begin
                        errs++;
                        $display("FAIL b2b_period: %0d cycles between dones, want %0d", cyc - last, W8 + 1);
                    end
                end
                last = cyc;
                ndone++;
                tick();
                i++;
                checks++;
                if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                    errs++;
                    $display("FAIL b2b_rearm: busy=%b done=%b after done, want 1 0", busy8, done8);
                end
            end
        end
        start8 = 1'b0;
        wait_idle8();
        tick();
        checks++;
        if (ndone < 4) begin
            errs++;
            $display("FAIL b2b_count: %0d results in 45 cycles, want >= 4", ndone);
        end
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        wait_idle8();
        tick();
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8} !== '0) begin
            errs++;
            $display("FAIL rst_mid: busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < W8 + 4; i++) begin
            tick();
            if (done8 || busy8) seen++;
        end
        checks++;
        if (seen != 0) begin
            errs++;
            $display("FAIL rst_nodone: %0d busy/done cycles after abort, want 0", seen);
        end
        run8(8'h03, 8'h04, 1'b0);
        checks++;
        if (sum8 !== 8'h07 || cout8 !== 1'b0) begin
            errs++;
            $display("FAIL rst_next: sum=%h cout=%b, want 07 0", sum8, cout8);
        end
        // Reset landing on the done cycle must drop done at once.
        run8(8'h05, 8'h06, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (done8 !== 1'b0 || sum8 !== 8'h00) begin
            errs++;
            $display("FAIL rst_done: done=%b sum=%h, want 0 00", done8, sum8);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [W8-1:0]  ra8, rb8;
        logic [W13-1:0] ra13, rb13;
        logic           rc;
        for (int i = 0; i < 500; i++) begin
            ra8 = W8'($urandom); rb8 = W8'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra8 = '1; rb8 = '1; rc = 1'b1; end
            run8(ra8, rb8, rc);
            checks++;
            if (32'({cout8, sum8}) !== 32'(ra8) + 32'(rb8) + 32'(rc)) begin
                errs++;
                $display("FAIL rand8: %h+%h+%b gave %h", ra8, rb8, rc, {cout8, sum8});
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        for (int i = 0; i < 500; i++) begin
            ra13 = W13'($urandom); rb13 = W13'($urandom); rc = 1'($urandom);
            if (i == 0) begin ra13 = '1; rb13 = '1; rc = 1'b1; end
            run13(ra13, rb13, rc);
            checks++;
            if (32'({cout13, sum13}) !== 32'(ra13) + 32'(rb13) + 32'(rc)) begin
                errs++;
                $display("FAIL rand13: %h+%h+%b gave %h", ra13, rb13, rc, {cout13, sum13});
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_two_ops();
        test_ignored_start();
        test_back_to_back();
        test_reset_midop();
        test_random();
        repeat (W13 + 4) tick();
        checks++;
        if (q8.size() != 0 || q13.size() != 0) begin
            errs++;
            $display("FAIL sb_drain: %0d/%0d results never completed, want 0/0", q8.size(), q13.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end
endmodule
